lc3_control_fsm: RTL and testbench
==================================

// Module: lc3_control_fsm
// PURPOSE
//  Instruction sequencer for the LC-3 datapath: Moore FSM that runs fetch/decode/execute.
//  Drives every gate, load, mux-select and memory strobe of the datapath from Opcode/BEN.
//  Sits beside the datapath in the top level; memory is SRAM with fixed wait states.
// PARAMETERS
//  MEM_WAIT  2  cycles each SRAM read/write is held (>=1); LD_MDR/Mem_WE timed from it
// PORTS
//  Clk       in   1  system clock, all state on rising edge
//  Reset     in   1  synchronous, active-high
//  Run       in   1  start execution from HALTED
//  Continue  in   1  release from PAUSE instruction
//  Opcode    in   4  IR[15:12]
//  IR_5      in   1  IR[5], register/immediate select for ADD/AND
//  IR_11     in   1  IR[11], JSR(1)/JSRR(0)
//  BEN       in   1  registered branch enable from datapath
//  LD_MAR, LD_MDR, LD_IR, LD_PC  out 1 each  register loads
//  LD_REG, LD_CC, LD_BEN         out 1 each  reg-file / nzp / BEN loads
//  GatePC, GateMDR, GateALU, GateMARMUX  out 1 each  bus drivers, at most one high
//  PCMUX     out  2  00 PC+1, 01 bus, 10 address adder
//  DRMUX     out  1  0 IR[11:9], 1 R7
//  SR1MUX    out  1  0 IR[11:9], 1 IR[8:6]
//  SR2MUX    out  1  0 SR2 reg, 1 sext(imm5)
//  ADDR1MUX  out  1  0 PC, 1 SR1
//  ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11
//  ALUK      out  2  00 ADD, 01 AND, 10 NOT, 11 PASS A
//  MIO_EN    out  1  1: MDR loads from memory, 0: from bus
//  Mem_WE    out  1  active-high SRAM write strobe
// BEHAVIOUR
//  - Reset: state HALTED, wait counter 0, every output 0. Reset mid-instruction aborts it;
//    next edge in HALTED, Mem_WE low that cycle. Run sampled only in HALTED.
//  - Outputs pure decode of current state; unlisted outputs 0 in every state.
//  - Fetch: S18 GatePC,LD_MAR,PCMUX=00,LD_PC -> S33 MIO_EN=1 for MEM_WAIT cycles, LD_MDR on
//    last only -> S35 GateMDR,LD_IR -> S32 LD_BEN, branch on Opcode.
//  - ADD 0001/AND 0101/NOT 1001: one state; SR1MUX=1,SR2MUX=IR_5,ALUK=00/01/10,GateALU,LD_REG,LD_CC.
//  - BR 0000: S0 -> S22 if BEN else S18; S22 ADDR1MUX=0,ADDR2MUX=10,PCMUX=10,LD_PC.
//  - JMP 1100: S12 SR1MUX=1,ADDR1MUX=1,ADDR2MUX=00,PCMUX=10,LD_PC.
//  - JSR 0100: S4 GatePC,DRMUX=1,LD_REG -> IR_11 ? S21(ADDR1MUX=0,ADDR2MUX=11)
//    : S20(SR1MUX=1,ADDR1MUX=1,ADDR2MUX=00); both PCMUX=10,LD_PC. R7 captured before PC changes.
//  - LDR 0110: S6 SR1MUX=1,ADDR1MUX=1,ADDR2MUX=01,GateMARMUX,LD_MAR -> S25 read wait as S33
//    -> S27 GateMDR,LD_REG,LD_CC.
//  - STR 0111: S7 as S6 -> S23 SR1MUX=0,ALUK=11,GateALU,LD_MDR,MIO_EN=0
//    -> S16 Mem_WE=1 for exactly MEM_WAIT cycles.
//  - PAUSE 1101: PAUSE1 until Continue=1 -> PAUSE2 until Continue=0 -> S18 (one step per press).
//  - Any other opcode: S32 -> S18 (NOP). Every instruction's final state -> S18.
//  - Wait counter cleared on entry to S33/S25/S16; $clog2(MEM_WAIT+1) bits; never wraps.
// STRUCTURE
//  - lc3_pkg: state_t enum, opcode localparams, PCMUX/ADDR2MUX/ALUK encodings.
//  - One sub-module: mem_wait_timer (start, done after MEM_WAIT cycles), shared by S33/S25/S16.
// TESTING
//  - Reset, Run pulse, IR=0x1283 (ADD R1,R2,R3), MEM_WAIT=2: S32 reached 5 cycles after S18;
//    ADD cycle GateALU=1,LD_REG=1,LD_CC=1,SR2MUX=0,ALUK=00.
//  - Opcode 0000 with BEN=1 -> S22 PCMUX=10,LD_PC=1; BEN=0 -> S18 next cycle, LD_PC=0.
//  - IR=0x7442 (STR): S23 ALUK=11,GateALU=1,LD_MDR=1,MIO_EN=0; Mem_WE high exactly 2 cycles.
//  - IR=0x4800 (JSR, IR_11=1): S4 DRMUX=1,GatePC=1,LD_REG=1; then S21 ADDR2MUX=11,LD_PC=1.
//  - PAUSE, Continue low 100 cycles: all LD_* stay 0; Continue high then low -> S18.
//  - Reset high during S16 -> next cycle HALTED, Mem_WE=0, all outputs 0; Run=0 stays halted.

Source files
------------

// File: rtl/lc3_control_fsm_pkg.sv
// Shared types for the LC-3 instruction sequencer.
// Contents: the sequencer state encoding, the opcode values it decodes, the
// datapath select encodings, and the packed control word that the sequencer
// registers before driving it onto the datapath.
package lc3_control_fsm_pkg;

  typedef enum logic [4:0] {
    ST_HALTED = 5'd0,
    ST_S18    = 5'd1,   // fetch: MAR <- PC, PC <- PC+1
    ST_S33    = 5'd2,   // fetch: SRAM read wait
    ST_S35    = 5'd3,   // fetch: IR <- MDR
    ST_S32    = 5'd4,   // decode, BEN <- nzp test
    ST_S1     = 5'd5,   // ADD
    ST_S5     = 5'd6,   // AND
    ST_S9     = 5'd7,   // NOT
    ST_S0     = 5'd8,   // BR test
    ST_S22    = 5'd9,   // BR taken
    ST_S12    = 5'd10,  // JMP
    ST_S4     = 5'd11,  // JSR: R7 <- PC
    ST_S21    = 5'd12,  // JSR: PC <- PC + off11
    ST_S20    = 5'd13,  // JSRR: PC <- SR1
    ST_S6     = 5'd14,  // LDR address
    ST_S25    = 5'd15,  // LDR read wait
    ST_S27    = 5'd16,  // LDR writeback
    ST_S7     = 5'd17,  // STR address
    ST_S23    = 5'd18,  // STR MDR <- SR
    ST_S16    = 5'd19,  // STR write strobe
    ST_PAUSE1 = 5'd20,  // wait for Continue press
    ST_PAUSE2 = 5'd21   // wait for Continue release
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_pc;
    logic       ld_reg;
    logic       ld_cc;
    logic       ld_ben;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       drmux;
    logic       sr1mux;
    logic       sr2mux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mio_en;
    logic       mem_we;
  } ctrl_t;

  // States that hold the SRAM for a fixed number of cycles.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_S33) || (s == ST_S25) || (s == ST_S16);
  endfunction

endpackage

// File: rtl/lc3_control_fsm_if.sv
// Sequencer <-> datapath bundle.
// master: the sequencer (reads status/IR fields, drives all controls).
// slave : the datapath (drives status/IR fields, consumes controls).
interface lc3_control_fsm_if;
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;

  logic       LD_MAR, LD_MDR, LD_IR, LD_PC;
  logic       LD_REG, LD_CC, LD_BEN;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic [1:0] ADDR2MUX;
  logic [1:0] ALUK;
  logic       MIO_EN;
  logic       Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN,
           GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
           SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, MIO_EN, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN,
           GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
           SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, MIO_EN, Mem_WE
  );
endinterface

// File: rtl/lc3_control_fsm_mem_wait_timer.sv
// SRAM wait-state timer shared by the read/write wait states.
// Ports: clk_i/rst_i clock and synchronous reset; start_i clears the count
// (next cycle is the first of a wait); hold_i advances it (staying in a wait);
// done_o marks the current cycle as the last wait cycle; last_next_o says the
// next cycle will be the last one (used by the registered control outputs).
module lc3_control_fsm_mem_wait_timer #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic hold_i,
  output logic done_o,
  output logic last_next_o
);
  localparam int            CW       = $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(MEM_WAIT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear on entry, saturating increment while held.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (hold_i && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o      = (cnt_q == CNT_LAST);
  assign last_next_o = (cnt_d == CNT_LAST);
endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 instruction sequencer: Moore FSM for fetch/decode/execute.
// Ports: Clk, Reset (synchronous, active-high); ctrl_if (master) carries
// Run/Continue/Opcode/IR_5/IR_11/BEN in and every datapath load, gate,
// mux select and SRAM strobe out. Outputs are registered: the control word
// for the next state is decoded and captured on the same edge as the state,
// so the visible outputs are always the decode of the current state.
module lc3_control_fsm
  import lc3_control_fsm_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  lc3_control_fsm_if.master ctrl_if
);
  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   wait_done_s, wait_last_next_s, wait_start_s, wait_hold_s;

  // Control word of a state; LD_MDR in a read wait only on its final cycle.
  function automatic ctrl_t decode(input state_t s, input logic last, input logic ir5);
    ctrl_t c;
    c = '0;
    case (s)
      ST_S18: begin c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.pcmux = PCMUX_PC1; c.ld_pc = 1'b1; end
      ST_S33, ST_S25: begin c.mio_en = 1'b1; c.ld_mdr = last; end
      ST_S35: begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
      ST_S32: c.ld_ben = 1'b1;
      ST_S1, ST_S5, ST_S9: begin
        c.sr1mux = 1'b1; c.sr2mux = ir5; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
        c.aluk = (s == ST_S1) ? ALUK_ADD : ((s == ST_S5) ? ALUK_AND : ALUK_NOT);
      end
      ST_S22: begin c.addr1mux = 1'b0; c.addr2mux = ADDR2_OFF9; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1; end
      ST_S12, ST_S20: begin
        c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = ADDR2_ZERO; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1;
      end
      ST_S4:  begin c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; end
      ST_S21: begin c.addr1mux = 1'b0; c.addr2mux = ADDR2_OFF11; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1; end
      ST_S6, ST_S7: begin
        c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = ADDR2_OFF6; c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
      end
      ST_S27: begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
      // Store source is IR[11:9] passed straight through the ALU onto the bus.
      ST_S23: begin c.sr1mux = 1'b0; c.aluk = ALUK_PASSA; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; c.mio_en = 1'b0; end
      ST_S16: c.mem_we = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  lc3_control_fsm_mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .start_i    (wait_start_s),
    .hold_i     (wait_hold_s),
    .done_o     (wait_done_s),
    .last_next_o(wait_last_next_s)
  );

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALTED: state_d = ctrl_if.Run ? ST_S18 : ST_HALTED;
      ST_S18:    state_d = ST_S33;
      ST_S33:    state_d = wait_done_s ? ST_S35 : ST_S33;
      ST_S35:    state_d = ST_S32;
      ST_S32: begin
        case (ctrl_if.Opcode)
          OP_ADD:   state_d = ST_S1;
          OP_AND:   state_d = ST_S5;
          OP_NOT:   state_d = ST_S9;
          OP_BR:    state_d = ST_S0;
          OP_JMP:   state_d = ST_S12;
          OP_JSR:   state_d = ST_S4;
          OP_LDR:   state_d = ST_S6;
          OP_STR:   state_d = ST_S7;
          OP_PAUSE: state_d = ST_PAUSE1;
          default:  state_d = ST_S18;
        endcase
      end
      ST_S0:     state_d = ctrl_if.BEN ? ST_S22 : ST_S18;
      ST_S4:     state_d = ctrl_if.IR_11 ? ST_S21 : ST_S20;
      ST_S6:     state_d = ST_S25;
      ST_S25:    state_d = wait_done_s ? ST_S27 : ST_S25;
      ST_S7:     state_d = ST_S23;
      ST_S23:    state_d = ST_S16;
      ST_S16:    state_d = wait_done_s ? ST_S18 : ST_S16;
      ST_PAUSE1: state_d = ctrl_if.Continue ? ST_PAUSE2 : ST_PAUSE1;
      ST_PAUSE2: state_d = ctrl_if.Continue ? ST_PAUSE2 : ST_S18;
      ST_S1, ST_S5, ST_S9, ST_S22, ST_S12,
      ST_S21, ST_S20, ST_S27: state_d = ST_S18;
      default:   state_d = ST_HALTED;
    endcase
  end

  // Timer control and the control word that goes with the next state.
  always_comb begin
    wait_start_s = is_wait_state(state_d) && (state_d != state_q);
    wait_hold_s  = is_wait_state(state_q) && (state_d == state_q);
    ctrl_d       = decode(state_d, wait_last_next_s, ctrl_if.IR_5);
  end

  // State and registered control outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_HALTED;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ctrl_if.LD_MAR     = ctrl_q.ld_mar;
  assign ctrl_if.LD_MDR     = ctrl_q.ld_mdr;
  assign ctrl_if.LD_IR      = ctrl_q.ld_ir;
  assign ctrl_if.LD_PC      = ctrl_q.ld_pc;
  assign ctrl_if.LD_REG     = ctrl_q.ld_reg;
  assign ctrl_if.LD_CC      = ctrl_q.ld_cc;
  assign ctrl_if.LD_BEN     = ctrl_q.ld_ben;
  assign ctrl_if.GatePC     = ctrl_q.gate_pc;
  assign ctrl_if.GateMDR    = ctrl_q.gate_mdr;
  assign ctrl_if.GateALU    = ctrl_q.gate_alu;
  assign ctrl_if.GateMARMUX = ctrl_q.gate_marmux;
  assign ctrl_if.PCMUX      = ctrl_q.pcmux;
  assign ctrl_if.DRMUX      = ctrl_q.drmux;
  assign ctrl_if.SR1MUX     = ctrl_q.sr1mux;
  assign ctrl_if.SR2MUX     = ctrl_q.sr2mux;
  assign ctrl_if.ADDR1MUX   = ctrl_q.addr1mux;
  assign ctrl_if.ADDR2MUX   = ctrl_q.addr2mux;
  assign ctrl_if.ALUK       = ctrl_q.aluk;
  assign ctrl_if.MIO_EN     = ctrl_q.mio_en;
  assign ctrl_if.Mem_WE     = ctrl_q.mem_we;
endmodule

// File: tb/tb_lc3_control_fsm.sv
// Self-checking bench for the LC-3 sequencer. Expected control words come
// from a per-instruction micro-step list built from the instruction rules;
// a constant table checks instruction length and strobe counts.
module tb_lc3_control_fsm;
  localparam int MW = 2;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  lc3_control_fsm_if ifc();
  lc3_control_fsm #(.MEM_WAIT(MW)) dut (.Clk(Clk), .Reset(Reset), .ctrl_if(ifc));

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic mio_en, mem_we;
  } cw_t;

  typedef struct {
    logic [3:0] op;
    logic ir5, ir11, ben;
    int len, n_pc, n_reg, n_cc, n_mdr, n_we;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  cw_t  exp_q[$];
  vec_t tbl[12];

  function automatic cw_t observed();
    cw_t c;
    c.ld_mar = ifc.LD_MAR;   c.ld_mdr = ifc.LD_MDR;   c.ld_ir = ifc.LD_IR;
    c.ld_pc = ifc.LD_PC;     c.ld_reg = ifc.LD_REG;   c.ld_cc = ifc.LD_CC;
    c.ld_ben = ifc.LD_BEN;   c.gate_pc = ifc.GatePC;  c.gate_mdr = ifc.GateMDR;
    c.gate_alu = ifc.GateALU; c.gate_marmux = ifc.GateMARMUX;
    c.pcmux = ifc.PCMUX;     c.drmux = ifc.DRMUX;     c.sr1mux = ifc.SR1MUX;
    c.sr2mux = ifc.SR2MUX;   c.addr1mux = ifc.ADDR1MUX; c.addr2mux = ifc.ADDR2MUX;
    c.aluk = ifc.ALUK;       c.mio_en = ifc.MIO_EN;   c.mem_we = ifc.Mem_WE;
    return c;
  endfunction

  task automatic chk_word(input string name, input cw_t act, input cw_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic cw_t w_fetch_start();
    cw_t c = '0;
    c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.pcmux = 2'b00;
    return c;
  endfunction

  // Memory access of MW cycles: reads strobe MDR on the final cycle only.
  task automatic push_mem(input bit write);
    for (int i = 0; i < MW; i++) begin
      cw_t c = '0;
      if (write) c.mem_we = 1'b1;
      else begin c.mio_en = 1'b1; c.ld_mdr = (i == MW - 1); end
      exp_q.push_back(c);
    end
  endtask

  // Steps after the fetch-start cycle up to and including decode.
  task automatic push_fetch();
    cw_t c;
    push_mem(1'b0);
    c = '0; c.gate_mdr = 1'b1; c.ld_ir = 1'b1; exp_q.push_back(c);
    c = '0; c.ld_ben = 1'b1; exp_q.push_back(c);
  endtask

  task automatic push_exec(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben);
    cw_t c;
    case (op)
      4'd1, 4'd5, 4'd9: begin
        c = '0; c.sr1mux = 1'b1; c.sr2mux = ir5; c.gate_alu = 1'b1;
        c.ld_reg = 1'b1; c.ld_cc = 1'b1;
        c.aluk = (op == 4'd1) ? 2'b00 : ((op == 4'd5) ? 2'b01 : 2'b10);
        exp_q.push_back(c);
      end
      4'd0: begin
        exp_q.push_back('0);
        if (ben) begin
          c = '0; c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1'b1; exp_q.push_back(c);
        end
      end
      4'd12: begin
        c = '0; c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.pcmux = 2'b10; c.ld_pc = 1'b1;
        exp_q.push_back(c);
      end
      4'd4: begin
        c = '0; c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; exp_q.push_back(c);
        c = '0; c.pcmux = 2'b10; c.ld_pc = 1'b1;
        if (ir11) c.addr2mux = 2'b11;
        else begin c.sr1mux = 1'b1; c.addr1mux = 1'b1; end
        exp_q.push_back(c);
      end
      4'd6, 4'd7: begin
        c = '0; c.sr1mux = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b01;
        c.gate_marmux = 1'b1; c.ld_mar = 1'b1; exp_q.push_back(c);
        if (op == 4'd6) begin
          push_mem(1'b0);
          c = '0; c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; exp_q.push_back(c);
        end else begin
          c = '0; c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1; exp_q.push_back(c);
          push_mem(1'b1);
        end
      end
      default: ;
    endcase
  endtask

  // Pops and compares one expected word per cycle.
  task automatic drain(input string tag);
    int i = 0;
    while (exp_q.size() > 0) begin
      cw_t e = exp_q.pop_front();
      @(negedge Clk);
      chk_word($sformatf("%s_c%0d", tag, i), observed(), e);
      i++;
    end
  endtask

  // Starting from a negedge showing fetch-start, checks one whole instruction
  // and the fetch-start of the next one.
  task automatic check_instr(input string tag, input logic [3:0] op, input logic ir5,
                             input logic ir11, input logic ben);
    ifc.Opcode = op; ifc.IR_5 = ir5; ifc.IR_11 = ir11; ifc.BEN = ben;
    exp_q.delete();
    push_fetch();
    push_exec(op, ir5, ir11, ben);
    exp_q.push_back(w_fetch_start());
    drain(tag);
  endtask

  task automatic run_counts(input int idx);
    cw_t c;
    int len, npc, nreg, ncc, nmdr, nwe;
    bit found = 1'b0;
    ifc.Opcode = tbl[idx].op; ifc.IR_5 = tbl[idx].ir5;
    ifc.IR_11 = tbl[idx].ir11; ifc.BEN = tbl[idx].ben;
    c = observed();
    len = 1; npc = int'(c.ld_pc); nreg = int'(c.ld_reg); ncc = int'(c.ld_cc);
    nmdr = int'(c.ld_mdr); nwe = int'(c.mem_we);
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge Clk);
      c = observed();
      if (c.gate_pc && c.ld_mar) found = 1'b1;
      else begin
        len++; npc += int'(c.ld_pc); nreg += int'(c.ld_reg); ncc += int'(c.ld_cc);
        nmdr += int'(c.ld_mdr); nwe += int'(c.mem_we);
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL tbl%0d_timeout: no next fetch within 40 cycles", idx);
    end
    chk_int($sformatf("tbl%0d_len", idx), len, tbl[idx].len);
    chk_int($sformatf("tbl%0d_ld_pc", idx), npc, tbl[idx].n_pc);
    chk_int($sformatf("tbl%0d_ld_reg", idx), nreg, tbl[idx].n_reg);
    chk_int($sformatf("tbl%0d_ld_cc", idx), ncc, tbl[idx].n_cc);
    chk_int($sformatf("tbl%0d_ld_mdr", idx), nmdr, tbl[idx].n_mdr);
    chk_int($sformatf("tbl%0d_mem_we", idx), nwe, tbl[idx].n_we);
  endtask

  task automatic run_pulse();
    ifc.Run = 1'b1;
    @(posedge Clk); #1;
    ifc.Run = 1'b0;
    @(negedge Clk);
    chk_word("run_fetch_start", observed(), w_fetch_start());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        op     ir5   ir11  ben   len pc reg cc mdr we
    tbl[0]  = '{4'h1, 1'b0, 1'b0, 1'b0, 6, 1, 1, 1, 1, 0};  // ADD
    tbl[1]  = '{4'h5, 1'b1, 1'b0, 1'b0, 6, 1, 1, 1, 1, 0};  // AND imm
    tbl[2]  = '{4'h9, 1'b1, 1'b0, 1'b0, 6, 1, 1, 1, 1, 0};  // NOT
    tbl[3]  = '{4'h0, 1'b0, 1'b0, 1'b1, 7, 2, 0, 0, 1, 0};  // BR taken
    tbl[4]  = '{4'h0, 1'b0, 1'b0, 1'b0, 6, 1, 0, 0, 1, 0};  // BR not taken
    tbl[5]  = '{4'hC, 1'b0, 1'b0, 1'b0, 6, 2, 0, 0, 1, 0};  // JMP
    tbl[6]  = '{4'h4, 1'b0, 1'b1, 1'b0, 7, 2, 1, 0, 1, 0};  // JSR
    tbl[7]  = '{4'h4, 1'b0, 1'b0, 1'b0, 7, 2, 1, 0, 1, 0};  // JSRR
    tbl[8]  = '{4'h6, 1'b0, 1'b0, 1'b0, 9, 1, 1, 1, 2, 0};  // LDR
    tbl[9]  = '{4'h7, 1'b0, 1'b0, 1'b0, 9, 1, 0, 0, 2, 2};  // STR
    tbl[10] = '{4'hF, 1'b0, 1'b0, 1'b0, 5, 1, 0, 0, 1, 0};  // unimplemented -> NOP
    tbl[11] = '{4'h3, 1'b1, 1'b1, 1'b1, 5, 1, 0, 0, 1, 0};  // unimplemented -> NOP

    // Reset: all controls low, and stay halted without Run.
    Reset = 1'b1; ifc.Run = 1'b0; ifc.Continue = 1'b0;
    ifc.Opcode = 4'h1; ifc.IR_5 = 1'b0; ifc.IR_11 = 1'b0; ifc.BEN = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_word("reset_outputs", observed(), '0);
    Reset = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      chk_word("halted_no_run", observed(), '0);
    end
    run_pulse();

    // ADD R1,R2,R3 (0x1283): decode appears on the 5th cycle counting from fetch start.
    check_instr("add_1283", 4'h1, 1'b0, 1'b0, 1'b0);
    check_instr("br_taken", 4'h0, 1'b0, 1'b0, 1'b1);
    check_instr("br_not_taken", 4'h0, 1'b0, 1'b0, 1'b0);
    check_instr("str_7442", 4'h7, 1'b0, 1'b0, 1'b0);
    check_instr("jsr_4800", 4'h4, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) run_counts(i);

    // PAUSE: idle until Continue pressed and released.
    ifc.Opcode = 4'hD; ifc.Continue = 1'b0;
    exp_q.delete();
    push_fetch();
    drain("pause_fetch");
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      chk_word($sformatf("pause1_idle%0d", i), observed(), '0);
    end
    ifc.Continue = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk_word($sformatf("pause2_idle%0d", i), observed(), '0);
    end
    ifc.Continue = 1'b0;
    @(negedge Clk);
    chk_word("pause_release", observed(), w_fetch_start());

    // Reset while the store strobe is active.
    ifc.Opcode = 4'h7; ifc.IR_5 = 1'b0; ifc.IR_11 = 1'b0;
    exp_q.delete();
    push_fetch();
    push_exec(4'h7, 1'b0, 1'b0, 1'b0);
    void'(exp_q.pop_back());   // stop on the first write-strobe cycle
    drain("str_pre_reset");
    Reset = 1'b1;
    @(negedge Clk);
    chk_word("reset_in_write", observed(), '0);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk_word($sformatf("halted_after_reset%0d", i), observed(), '0);
    end
    run_pulse();

    // Randomized instruction stream; Run/Continue noise must be ignored.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'hD) op = 4'h1;
      ifc.Run = 1'($urandom_range(0, 1));
      ifc.Continue = 1'($urandom_range(0, 1));
      check_instr($sformatf("rnd%0d_op%h", i, op), op, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
